// File: rtl/updown4_pkg.sv
// Shared constants for the updown4 counter: direction encoding and default width.
package updown4_pkg;
  localparam int   DEF_WIDTH = 4;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
endpackage

// File: rtl/updown4_if.sv
// Counter bus: direction request from the consumer and the registered count back to it.
import updown4_pkg::*;

interface updown4_if #(parameter int WIDTH = DEF_WIDTH);
  logic             dir;
  logic [WIDTH-1:0] q;

  modport master (output dir, input  q);
  modport slave  (input  dir, output q);
endinterface

// File: rtl/updown4.sv
// Free-running up/down counter. It wraps modulo 2^WIDTH and is cleared asynchronously to RST_VAL.
module updown4
  import updown4_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic      clk,
  input  logic      rst,
  updown4_if.slave  bus
);

  if (WIDTH < 1) begin : g_width_chk
    $error("updown4: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] r_q;

  // Truncating add/sub wraps in both directions, so no compare against the limits is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_q <= RST_VAL;
    else if (bus.dir == DIR_UP) r_q <= r_q + WIDTH'(1);
    else                      r_q <= r_q - WIDTH'(1);
  end

  assign bus.q = r_q;

endmodule

// File: tb/tb_updown4.sv
// Bench for updown4: table-driven directed vectors, multi-cycle corner sequences, then random dir/reset against a modulo-16 model.
module tb_updown4;
  import updown4_pkg::*;

  typedef struct {
    logic       rst;
    logic       dir;
    logic [3:0] exp;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dir = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   mref  = 0;
  vec_t vecs[$];

  updown4_if #(.WIDTH(4)) bus ();
  assign bus.dir = dir;

  updown4 #(.WIDTH(4), .RST_VAL(4'd0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [3:0] act, input int exp);
    tests++;
    if (act !== 4'(exp)) begin
      fails++;
      $display("FAIL %s: q=%0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model one edge from the inputs present at that edge, then sample q 1 ns later.
  task automatic edge_check(input string nm);
    @(posedge clk);
    if (rst) mref = 0;
    else     mref = (mref + (dir ? 1 : 15)) % 16;
    #1;
    check(nm, bus.q, mref);
  endtask

  initial begin
    vecs.push_back('{1'b1, 1'b1, 4'd0, "rst_hold"});
    for (int k = 1; k <= 10; k++) vecs.push_back('{1'b0, 1'b1, 4'(k), "count_up"});
    for (int k = 9; k >= 0; k--)  vecs.push_back('{1'b0, 1'b0, 4'(k), "count_down"});
    vecs.push_back('{1'b0, 1'b0, 4'd15, "under_wrap"});
    vecs.push_back('{1'b0, 1'b0, 4'd14, "down_14"});
    vecs.push_back('{1'b0, 1'b1, 4'd15, "up_15"});
    vecs.push_back('{1'b0, 1'b1, 4'd0,  "up_wrap"});
    vecs.push_back('{1'b0, 1'b1, 4'd1,  "up_after_wrap"});

    // An asynchronous clear must show before the first clock edge.
    #1 rst = 1'b1;
    #1 check("async_rst_init", bus.q, 0);
    mref = 0;

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      dir = vecs[i].dir;
      edge_check({vecs[i].name, "_model"});
      check(vecs[i].name, bus.q, int'(vecs[i].exp));
    end

    // Reset mid-count: clear between edges, hold across an edge, and release to a single step
    dir = DIR_UP;
    for (int k = 0; k < 4; k++) edge_check("pre_rst_up");
    #3 rst = 1'b1;
    #1 check("async_rst_mid", bus.q, 0);
    mref = 0;
    dir = DIR_DOWN;
    edge_check("rst_priority");
    check("rst_priority_zero", bus.q, 0);
    #3 rst = 1'b0;
    dir = DIR_UP;
    edge_check("release_step");
    check("release_is_one", bus.q, 1);

    // Direction change 2 ns after an edge: q stays put until the next edge, which steps in the new direction
    for (int k = 0; k < 6; k++) begin
      #1 dir = ~dir;
      #1 check("no_glitch", bus.q, mref);
      edge_check("dir_toggle");
    end

    // Random dir with occasional asynchronous reset pulses
    for (int n = 0; n < 300; n++) begin
      dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        #2 rst = 1'b1;
        #1 check("rand_async_clr", bus.q, 0);
        mref = 0;
        edge_check("rand_rst_hold");
        rst = 1'b0;
        dir = 1'($urandom_range(0, 1));
      end
      edge_check("rand_step");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
